admo_div: RTL and testbench
===========================

# admo_div

Iterative restoring divider for the ADMO core. It computes signed or unsigned quotient or remainder over several cycles using a start/done handshake. It sits beside the single-cycle ALU in the execute stage. The core stalls while `div_busy` is high and takes `div_res` when `div_done` pulses.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `div_start`  in  1  request; accepted only when `div_ready` is high.
- `div_op`  in  2  operation select: `` `DIV_DIV ``=00, `` `DIV_DIVU ``=01, `` `DIV_REM ``=10, `` `DIV_REMU ``=11.
- `div_a`  in  DATA_WIDTH  dividend; sampled on accept.
- `div_b`  in  DATA_WIDTH  divisor; sampled on accept.
- `div_ready`  out  1  high in IDLE only.
- `div_busy`  out  1  high in CALC and DONE.
- `div_done`  out  1  one-cycle pulse; `div_res` is valid during the pulse.
- `div_res`  out  DATA_WIDTH  registered result; holds until the next completion.

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE.
- Reset values: `div_ready`=1, `div_busy`=0, `div_done`=0, `div_res`=0, step counter=0.
- Accept: `div_start & div_ready`. On accept, latch op, operand signs and `|a|`, `|b|`. Signed ops take the magnitude; unsigned ops take the operand as-is.
- IDLE → CALC: normal accept. Counter loads DATA_WIDTH, partial remainder clears to 0, quotient register loads `|a|`.
- IDLE → DONE: fast path, taken directly on accept in either case below.
  - Divisor == 0: quotient = all-ones, remainder = `div_a` unmodified.
  - Signed overflow (`div_a`=most-negative, `div_b`=−1, signed op): quotient = most-negative, remainder = 0.
- CALC, one restoring step per cycle:
  - shift {rem, quo} left 1;
  - trial = rem − `|b|` at DATA_WIDTH+1 bits;
  - if trial ≥ 0, rem ← trial and quo LSB ← 1, else quo LSB ← 0;
  - counter decrements.
  - counter reaching 1 on a step → DONE next cycle.
- DONE: register `div_res` and assert `div_done` for exactly one cycle, then go to IDLE.
  - DIV: quotient negated when the operand signs differ.
  - REM: remainder takes the sign of `div_a`.
  - Unsigned ops apply no correction.
- `div_start` while busy is ignored; no queueing.
- `div_start` in the DONE cycle is ignored, because `div_ready` is still 0.
- `rst` mid-operation aborts the operation: IDLE next cycle, no `div_done`, `div_res` cleared to 0.

## Timing
- Accept at edge of cycle 0.
- Normal path:
  - CALC during cycles 1..DATA_WIDTH;
  - DONE in cycle DATA_WIDTH+1 with `div_done`=1;
  - `div_ready`=1 again in cycle DATA_WIDTH+2.
  - Latency is DATA_WIDTH+1 cycles, 33 at default.
- Fast path: DONE in cycle 1, back in IDLE in cycle 2.
- Throughput is one operation per DATA_WIDTH+2 cycles. The earliest next accept is in the cycle after DONE.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Defines in `admo_defs.v`: `` `DIV_DIV ``, `` `DIV_DIVU ``, `` `DIV_REM ``, `` `DIV_REMU ``, plus the state encodings.
- Sub-module `admo_div_step`: combinational single restoring iteration.
  - in: rem, quo, divisor;
  - out: next rem, next quo.
- Top level holds the FSM, counter, operand latching and sign correction.

## Test plan
- DIVU 100/7: `div_done` in cycle 33 with `div_res`=14. REMU 100/7: `div_res`=2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM same operands → 0xFFFFFFFF (−1).
- DIVU 5/0 → 0xFFFFFFFF in cycle 1. REMU 5/0 → 5 in cycle 1.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same operands → 0. Both complete in cycle 1.
- Second `div_start` during CALC and during DONE: ignored, exactly one `div_done`, result matches the first request only.
- `rst` high in cycle 10 of CALC: IDLE next cycle, `div_ready`=1, `div_res`=0, no `div_done` observed afterwards.

Source files
------------

// File: rtl/admo_div_pkg.sv
// Shared types for the ADMO iterative divider: operation codes, FSM states
// and small decode helpers used by the divider top level.
package admo_div_pkg;

    localparam int DIV_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Bit 0 clear means a signed operation, bit 1 set means remainder.
    function automatic logic op_is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/admo_div_step.sv
// One combinational restoring-division iteration over a {rem, quo} pair.
module admo_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] next_rem,
    output logic [DATA_WIDTH-1:0] next_quo
);

    logic [DATA_WIDTH:0] rem_shift;
    logic                trial_ok;

    // The shifted remainder needs one extra bit; the trial result always fits back in DATA_WIDTH.
    assign rem_shift = {rem, quo[DATA_WIDTH-1]};
    assign trial_ok  = (rem_shift >= {1'b0, divisor});
    assign next_rem  = trial_ok ? DATA_WIDTH'(rem_shift - {1'b0, divisor})
                                : rem_shift[DATA_WIDTH-1:0];
    assign next_quo  = {quo[DATA_WIDTH-2:0], trial_ok};

endmodule

// File: rtl/admo_div.sv
// ADMO iterative divider: start/done handshake around a restoring divider,
// with fast completion for divide-by-zero and signed overflow.
module admo_div
    import admo_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start,
    input  logic [1:0]            div_op,
    input  logic [DATA_WIDTH-1:0] div_a,
    input  logic [DATA_WIDTH-1:0] div_b,
    output logic                  div_ready,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [DATA_WIDTH-1:0] div_res
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e state, state_next;

    div_op_e               op_in;
    div_op_e               op_q;
    logic                  a_neg_q, b_neg_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, divisor_q, res_q;
    logic [CW-1:0]         count_q;

    logic                  accept;
    logic                  a_neg, b_neg;
    logic [DATA_WIDTH-1:0] a_mag, b_mag;
    logic                  div_zero, overflow, fast;
    logic [DATA_WIDTH-1:0] fast_res;
    logic [DATA_WIDTH-1:0] step_rem, step_quo;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix, calc_res;
    logic                  last_step;

    assign op_in  = div_op_e'(div_op);
    assign accept = div_start & (state == ST_IDLE);

    // Signed operations work on magnitudes; the most-negative value maps onto itself, which is correct unsigned.
    always_comb begin
        a_neg    = op_is_signed(op_in) & div_a[DATA_WIDTH-1];
        b_neg    = op_is_signed(op_in) & div_b[DATA_WIDTH-1];
        a_mag    = a_neg ? -div_a : div_a;
        b_mag    = b_neg ? -div_b : div_b;
        div_zero = (div_b == '0);
        overflow = op_is_signed(op_in) & (div_a == MOST_NEG) & (div_b == '1);
        fast     = div_zero | overflow;
        if (op_is_rem(op_in)) begin
            fast_res = div_zero ? div_a : '0;
        end else begin
            fast_res = div_zero ? '1 : MOST_NEG;
        end
    end

    admo_div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .next_rem(step_rem),
        .next_quo(step_quo)
    );

    assign last_step = (state == ST_CALC) && (count_q == CW'(1));

    // Sign correction is applied to the final step output so the result is registered on entry to DONE.
    always_comb begin
        quo_fix = step_quo;
        rem_fix = step_rem;
        if (op_q == OP_DIV && (a_neg_q ^ b_neg_q)) begin
            quo_fix = -step_quo;
        end
        if (op_q == OP_REM && a_neg_q) begin
            rem_fix = -step_rem;
        end
        calc_res = op_is_rem(op_q) ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        div_ready  = 1'b0;
        div_busy   = 1'b0;
        div_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                div_ready = 1'b1;
                if (accept) begin
                    state_next = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                div_busy = 1'b1;
                if (count_q == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                div_busy   = 1'b1;
                div_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_DIV;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            res_q     <= '0;
        end else begin
            if (accept) begin
                op_q      <= op_in;
                a_neg_q   <= a_neg;
                b_neg_q   <= b_neg;
                rem_q     <= '0;
                quo_q     <= a_mag;
                divisor_q <= b_mag;
                count_q   <= CW'(DATA_WIDTH);
                if (fast) begin
                    res_q <= fast_res;
                end
            end else if (state == ST_CALC) begin
                rem_q   <= step_rem;
                quo_q   <= step_quo;
                count_q <= count_q - CW'(1);
                if (last_step) begin
                    res_q <= calc_res;
                end
            end
        end
    end

    assign div_res = res_q;

endmodule

// File: tb/tb_admo_div.sv
// Self-checking bench for admo_div: spec-level model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_admo_div;
    import admo_div_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MOST_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         div_start = 1'b0;
    logic [1:0]   div_op = 2'b00;
    logic [W-1:0] div_a = '0;
    logic [W-1:0] div_b = '0;
    logic         div_ready, div_busy, div_done;
    logic [W-1:0] div_res;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    admo_div #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_start(div_start),
        .div_op   (div_op),
        .div_a    (div_a),
        .div_b    (div_b),
        .div_ready(div_ready),
        .div_busy (div_busy),
        .div_done (div_done),
        .div_res  (div_res)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Spec-level arithmetic: what the divider must return for one request.
    function automatic logic [W-1:0] model_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit is_signed = (op == OP_DIV) || (op == OP_REM);
        bit want_rem  = (op == OP_REM) || (op == OP_REMU);
        int sa, sb;
        if (b == '0) return want_rem ? a : '1;
        if (is_signed && a == MOST_NEG && b == '1) return want_rem ? '0 : MOST_NEG;
        if (is_signed) begin
            sa = $signed(a);
            sb = $signed(b);
            return want_rem ? W'(sa % sb) : W'(sa / sb);
        end
        return want_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit model_fast(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit is_signed = (op == OP_DIV) || (op == OP_REM);
        return (b == '0) || (is_signed && a == MOST_NEG && b == '1);
    endfunction

    // Model: cycles left in the busy window; the last busy cycle is the done pulse.
    int           m_left = 0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_res  = '0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (div_start) begin
            m_pend = model_result(div_op, div_a, div_b);
            m_left = model_fast(div_op, div_a, div_b) ? 1 : W + 1;
        end
        if (m_left == 1) m_res = m_pend;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("ready", W'(div_ready), W'(m_left == 0));
            check("busy",  W'(div_busy),  W'(m_left > 0));
            check("done",  W'(div_done),  W'(m_left == 1));
            check("res",   div_res,       m_res);
        end
    end

    // Called just after a rising edge with the divider idle; returns at the start of the cycle after done.
    task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output int lat);
        div_start = 1'b1;
        div_op    = op;
        div_a     = a;
        div_b     = b;
        @(posedge clk);
        #1 div_start = 1'b0;
        lat = 0;
        res = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (div_done) begin
                res = div_res;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [W-1:0] res, input int lat,
                                input logic [W-1:0] exp_res, input int exp_lat);
        check({name, "_res"}, res, exp_res);
        check({name, "_lat"}, W'(lat), W'(exp_lat));
    endtask

    typedef struct {
        div_op_e      op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    vec_t vecs [18] = '{
        '{OP_DIVU, 32'd100,       32'd7,         32'd14,        33},
        '{OP_REMU, 32'd100,       32'd7,         32'd2,         33},
        '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
        '{OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
        '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
        '{OP_REMU, 32'd5,         32'd0,         32'd5,         1},
        '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1},
        '{OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33},
        '{OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33},
        '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33},
        '{OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33},
        '{OP_DIV,  32'h8000_0000, 32'd2,         32'hC000_0000, 33},
        '{OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33},
        '{OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1},
        '{OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1},
        '{OP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33},
        '{OP_DIV,  32'd0,         32'd5,         32'd0,         33}
    };

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] res;
        logic [1:0]   op;
        logic [W-1:0] a, b;
        int           lat, dones;

        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(div_ready), W'(1));
        check("rst_busy",  W'(div_busy),  W'(0));
        check("rst_done",  W'(div_done),  W'(0));
        check("rst_res",   div_res,       '0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check_output($sformatf("vec%0d", i), res, lat, vecs[i].res, vecs[i].lat);
        end

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            apply_stimulus(op, a, b, res, lat);
            check_output($sformatf("rand%0d", i), res, lat, model_result(op, a, b),
                         model_fast(op, a, b) ? 1 : W + 1);
        end

        // Extra requests during CALC and during the DONE cycle must be dropped.
        div_start = 1'b1;
        div_op    = OP_DIVU;
        div_a     = 32'd100;
        div_b     = 32'd7;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 div_start = 1'b1;
        div_a = 32'd1000;
        div_b = 32'd3;
        @(posedge clk);
        #1 div_start = 1'b0;
        dones = 0;
        res   = '0;
        lat   = 0;
        while (lat < 100 && dones == 0) begin
            @(negedge clk);
            lat++;
            if (div_done) begin
                dones++;
                res = div_res;
                div_start = 1'b1;
                div_a = 32'd9;
                div_b = 32'd0;
            end
        end
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        check("busy_start_dones", W'(dones), W'(1));
        check("busy_start_res", res, 32'd14);
        @(posedge clk);
        #1;

        // Reset in cycle 10 of CALC aborts the division.
        div_start = 1'b1;
        div_op    = OP_DIVU;
        div_a     = 32'd100;
        div_b     = 32'd7;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", W'(div_ready), W'(1));
        check("abort_busy",  W'(div_busy),  W'(0));
        check("abort_res",   div_res,       '0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        check("abort_dones", W'(dones), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
